// File: rtl/gm1_syndrome_decoder.sv
// Receive-side decoder for the (6,3) systematic block code: syndrome against a
// programmable parity-check matrix, single-bit correction, saturating statistics.
module gm1_syndrome_decoder #(
  parameter logic [5:0]  H1_DEF = 6'b001110,
  parameter logic [5:0]  H2_DEF = 6'b010101,
  parameter logic [5:0]  H3_DEF = 6'b100011,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [5:0]       h1,
  input  logic [5:0]       h2,
  input  logic [5:0]       h3,
  input  logic             cfg_load,
  output logic             cfg_ack,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_msg,
  output logic [5:0]       out_word,
  output logic [2:0]       out_syn,
  output logic             out_corr,
  output logic             out_unc,
  output logic [2:0]       out_pos,
  output logic [CNT_W-1:0] cnt_corr,
  output logic [CNT_W-1:0] cnt_unc,
  input  logic             cnt_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [2:0] calc_syn(input logic [5:0] w, input logic [5:0] r1,
                                          input logic [5:0] r2, input logic [5:0] r3);
    return {^(r3 & w), ^(r2 & w), ^(r1 & w)};
  endfunction

  function automatic logic [5:0] col_match(input logic [2:0] syn, input logic [5:0] r1,
                                           input logic [5:0] r2, input logic [5:0] r3);
    logic [5:0] m;
    for (int j = 0; j < 6; j++) begin
      m[j] = ({r3[j], r2[j], r1[j]} == syn);
    end
    return m;
  endfunction

  function automatic logic [2:0] onehot_pos(input logic [5:0] m);
    logic [2:0] p;
    case (m)
      6'b000001: p = 3'd0;
      6'b000010: p = 3'd1;
      6'b000100: p = 3'd2;
      6'b001000: p = 3'd3;
      6'b010000: p = 3'd4;
      6'b100000: p = 3'd5;
      default:   p = 3'd7;
    endcase
    return p;
  endfunction

  logic [5:0]       h1_r, h2_r, h3_r;
  logic             cfg_pending_r, cfg_ack_r;
  logic             s1_valid_r;
  logic [5:0]       s1_word_r;
  logic             s2_valid_r;
  logic [5:0]       s2_word_r;
  logic [2:0]       s2_syn_r;
  logic             s2_corr_r, s2_unc_r;
  logic [2:0]       s2_pos_r;
  logic [CNT_W-1:0] cnt_corr_r, cnt_unc_r;

  logic       s2_adv_s, s1_take_s, accept_s, handoff_s, cfg_write_s;
  logic [2:0] dec_syn_s, dec_pos_s;
  logic [5:0] dec_match_s, dec_word_s;
  logic       dec_single_s, dec_corr_s, dec_unc_s;

  assign s2_adv_s    = en & (~s2_valid_r | out_ready);
  assign s1_take_s   = en & (~s1_valid_r | s2_adv_s);
  assign in_ready    = s1_take_s & ~cfg_pending_r;
  assign accept_s    = in_valid & in_ready;
  assign handoff_s   = en & s2_valid_r & out_ready;
  assign cfg_write_s = cfg_pending_r & ~s1_valid_r & ~s2_valid_r;

  // Decode the S1 word; a syndrome hitting several columns is left uncorrected.
  always_comb begin
    dec_syn_s    = calc_syn(s1_word_r, h1_r, h2_r, h3_r);
    dec_match_s  = col_match(dec_syn_s, h1_r, h2_r, h3_r);
    dec_single_s = (dec_match_s != 6'd0) && ((dec_match_s & (dec_match_s - 6'd1)) == 6'd0);
    dec_word_s   = s1_word_r;
    dec_pos_s    = 3'd7;
    dec_corr_s   = 1'b0;
    dec_unc_s    = 1'b0;
    if (dec_syn_s == 3'd0) begin
      dec_corr_s = 1'b0;
      dec_unc_s  = 1'b0;
    end else if (dec_single_s) begin
      dec_word_s = s1_word_r ^ dec_match_s;
      dec_pos_s  = onehot_pos(dec_match_s);
      dec_corr_s = 1'b1;
    end else begin
      dec_unc_s = 1'b1;
    end
  end

  // Parity-check rows are only rewritten once both stages have drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h1_r          <= H1_DEF;
      h2_r          <= H2_DEF;
      h3_r          <= H3_DEF;
      cfg_pending_r <= 1'b0;
      cfg_ack_r     <= 1'b0;
    end else if (en) begin
      if (cfg_write_s) begin
        h1_r          <= h1;
        h2_r          <= h2;
        h3_r          <= h3;
        cfg_pending_r <= 1'b0;
        cfg_ack_r     <= 1'b1;
      end else begin
        cfg_ack_r <= 1'b0;
        if (cfg_load) begin
          cfg_pending_r <= 1'b1;
        end
      end
    end
  end

  // Two-stage pipeline; S2 fields are frozen while the sink stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_word_r  <= 6'd0;
      s2_valid_r <= 1'b0;
      s2_word_r  <= 6'd0;
      s2_syn_r   <= 3'd0;
      s2_corr_r  <= 1'b0;
      s2_unc_r   <= 1'b0;
      s2_pos_r   <= 3'd7;
    end else if (en) begin
      if (s1_take_s) begin
        s1_valid_r <= accept_s;
        if (accept_s) begin
          s1_word_r <= in_word;
        end
      end
      if (s2_adv_s) begin
        s2_valid_r <= s1_valid_r;
        if (s1_valid_r) begin
          s2_word_r <= dec_word_s;
          s2_syn_r  <= dec_syn_s;
          s2_corr_r <= dec_corr_s;
          s2_unc_r  <= dec_unc_s;
          s2_pos_r  <= dec_pos_s;
        end
      end
    end
  end

  // Saturating statistics; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_corr_r <= '0;
      cnt_unc_r  <= '0;
    end else if (en) begin
      if (cnt_clr) begin
        cnt_corr_r <= '0;
        cnt_unc_r  <= '0;
      end else begin
        if (handoff_s && s2_corr_r && (cnt_corr_r != CNT_MAX)) begin
          cnt_corr_r <= cnt_corr_r + CNT_ONE;
        end
        if (handoff_s && s2_unc_r && (cnt_unc_r != CNT_MAX)) begin
          cnt_unc_r <= cnt_unc_r + CNT_ONE;
        end
      end
    end
  end

  assign cfg_ack   = cfg_ack_r;
  assign out_valid = s2_valid_r;
  assign out_word  = s2_word_r;
  assign out_msg   = s2_word_r[2:0];
  assign out_syn   = s2_syn_r;
  assign out_corr  = s2_corr_r;
  assign out_unc   = s2_unc_r;
  assign out_pos   = s2_pos_r;
  assign cnt_corr  = cnt_corr_r;
  assign cnt_unc   = cnt_unc_r;

endmodule

// File: tb/tb_gm1_syndrome_decoder.sv
// Self-checking bench for gm1_syndrome_decoder: directed vector table, corner
// sequences, and a random stream scored against a behavioural decode model.
module tb_gm1_syndrome_decoder;

  localparam int CW = 2;
  localparam logic [5:0] D1 = 6'b001110;
  localparam logic [5:0] D2 = 6'b010101;
  localparam logic [5:0] D3 = 6'b100011;

  logic clk = 1'b0;
  logic rst_n, en, cfg_load, cfg_ack, in_valid, in_ready, out_valid, out_ready;
  logic cnt_clr, out_corr, out_unc;
  logic [5:0] h1, h2, h3, in_word, out_word;
  logic [2:0] out_msg, out_syn, out_pos;
  logic [CW-1:0] cnt_corr, cnt_unc;
  logic [16:0] obs;

  gm1_syndrome_decoder #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .h1(h1), .h2(h2), .h3(h3),
    .cfg_load(cfg_load), .cfg_ack(cfg_ack), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .out_valid(out_valid), .out_ready(out_ready), .out_msg(out_msg),
    .out_word(out_word), .out_syn(out_syn), .out_corr(out_corr), .out_unc(out_unc),
    .out_pos(out_pos), .cnt_corr(cnt_corr), .cnt_unc(cnt_unc), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  assign obs = {out_word, out_syn, out_corr, out_unc, out_pos, out_msg};

  typedef struct packed {
    logic [5:0] cword;
    logic [2:0] syn;
    logic       corr;
    logic       unc;
    logic [2:0] pos;
    logic [2:0] msg;
  } res_t;

  typedef struct packed {
    logic [5:0] in;
    res_t       exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int hs_total = 0;
  int mc_corr, mc_unc;
  logic [5:0] mh1, mh2, mh3, hp1, hp2, hp3;
  res_t sbq[$];
  logic stall_prev, ack_prev, acc_flag, hs_flag, s_ack, s_in_ready;
  logic [16:0] held, last_got;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Syndrome bit k is the parity of the ones shared by row k and the word.
  function automatic logic [2:0] ref_syn(input logic [5:0] w, input logic [5:0] a,
                                         input logic [5:0] b, input logic [5:0] c);
    logic [2:0] s;
    s[0] = ($countones(a & w) % 2) == 1;
    s[1] = ($countones(b & w) % 2) == 1;
    s[2] = ($countones(c & w) % 2) == 1;
    return s;
  endfunction

  // A word is correctable when exactly one single-bit flip yields a codeword.
  function automatic res_t ref_dec(input logic [5:0] w, input logic [5:0] a,
                                   input logic [5:0] b, input logic [5:0] c);
    res_t r;
    int n = 0;
    int last = 7;
    logic [5:0] t;
    for (int j = 0; j < 6; j++) begin
      t = w ^ (6'd1 << j);
      if (ref_syn(t, a, b, c) == 3'd0) begin
        n++;
        last = j;
      end
    end
    r.syn = ref_syn(w, a, b, c);
    r.cword = w; r.corr = 1'b0; r.unc = 1'b0; r.pos = 3'd7;
    if (r.syn != 3'd0 && n == 1) begin
      r.cword = w ^ (6'd1 << last);
      r.corr = 1'b1;
      r.pos = 3'(last);
    end else if (r.syn != 3'd0) begin
      r.unc = 1'b1;
    end
    r.msg = r.cword[2:0];
    return r;
  endfunction

  function automatic vec_t mk(input logic [5:0] in, input logic [2:0] syn, input logic [5:0] cw,
                              input logic c, input logic u, input logic [2:0] p);
    vec_t v;
    v.in = in; v.exp.syn = syn; v.exp.cword = cw; v.exp.corr = c; v.exp.unc = u;
    v.exp.pos = p; v.exp.msg = cw[2:0];
    return v;
  endfunction

  task automatic model_reset();
    sbq.delete();
    mc_corr = 0; mc_unc = 0;
    mh1 = D1; mh2 = D2; mh3 = D3; hp1 = D1; hp2 = D2; hp3 = D3;
    stall_prev = 1'b0; ack_prev = 1'b0;
  endtask

  // One clock: observe at the falling edge, then return just after the rising edge.
  task automatic cycle();
    res_t e;
    @(negedge clk);
    chk("cnt_corr", 32'(cnt_corr), 32'(mc_corr));
    chk("cnt_unc", 32'(cnt_unc), 32'(mc_unc));
    if (stall_prev) chk("stall_hold", 32'({out_valid, obs}), 32'({1'b1, held}));
    if (cfg_ack && !ack_prev) begin
      mh1 = hp1; mh2 = hp2; mh3 = hp3;
    end
    ack_prev = cfg_ack; hp1 = h1; hp2 = h2; hp3 = h3;
    s_ack = cfg_ack; s_in_ready = in_ready;
    if (!en) chk("ready_when_disabled", 32'(in_ready), 32'd0);
    acc_flag = in_valid && in_ready && en;
    hs_flag = out_valid && out_ready && en;
    e = '0;
    if (hs_flag) begin
      hs_total++;
      if (sbq.size() == 0) begin
        chk("unexpected_output", 32'(sbq.size()), 32'd1);
      end else begin
        e = sbq.pop_front();
        chk("result", 32'(obs), 32'(e));
      end
      last_got = obs;
    end
    if (en && cnt_clr) begin
      mc_corr = 0; mc_unc = 0;
    end else if (hs_flag) begin
      if (e.corr && mc_corr < 3) mc_corr++;
      if (e.unc && mc_unc < 3) mc_unc++;
    end
    if (acc_flag) sbq.push_back(ref_dec(in_word, mh1, mh2, mh3));
    stall_prev = out_valid && !(en && out_ready);
    held = obs;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc();
    acc_flag = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (acc_flag) break;
    end
    chk("accept_timeout", 32'(acc_flag), 32'd1);
  endtask

  task automatic wait_hs(output int n);
    n = 0;
    hs_flag = 1'b0;
    while (!hs_flag && n < 12) begin
      cycle();
      n++;
    end
    chk("output_timeout", 32'(hs_flag), 32'd1);
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1; en = 1'b1; cfg_load = 1'b0; cnt_clr = 1'b0;
    for (int k = 0; k < 30 && (sbq.size() != 0 || out_valid); k++) cycle();
    chk("drain_empty", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    int n, start;
    logic tog;
    rst_n = 1'b0; en = 1'b1; cfg_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cnt_clr = 1'b0; in_word = 6'd0; h1 = D1; h2 = D2; h3 = D3;
    model_reset();
    vecs[0] = mk(6'b110001, 3'b000, 6'b110001, 1'b0, 1'b0, 3'd7);
    vecs[1] = mk(6'b100001, 3'b010, 6'b110001, 1'b1, 1'b0, 3'd4);
    vecs[2] = mk(6'b010101, 3'b111, 6'b010101, 1'b0, 1'b1, 3'd7);
    vecs[3] = mk(6'b110000, 3'b110, 6'b110001, 1'b1, 1'b0, 3'd0);
    vecs[4] = mk(6'b100010, 3'b001, 6'b101010, 1'b1, 1'b0, 3'd3);
    vecs[5] = mk(6'b000100, 3'b011, 6'b000000, 1'b1, 1'b0, 3'd2);
    vecs[6] = mk(6'b111111, 3'b111, 6'b111111, 1'b0, 1'b1, 3'd7);
    vecs[7] = mk(6'b100000, 3'b100, 6'b000000, 1'b1, 1'b0, 3'd5);
    vecs[8] = mk(6'b000000, 3'b000, 6'b000000, 1'b0, 1'b0, 3'd7);
    vecs[9] = mk(6'b000010, 3'b101, 6'b000000, 1'b1, 1'b0, 3'd1);

    #12;
    chk("reset_state", 32'({out_valid, cfg_ack, obs, cnt_corr, cnt_unc}),
        32'({1'b0, 1'b0, 6'd0, 3'd0, 1'b0, 1'b0, 3'd7, 3'd0, 2'd0, 2'd0}));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed vectors under the default matrix, one word at a time.
    for (int i = 0; i < 10; i++) begin
      in_word = vecs[i].in; in_valid = 1'b1;
      wait_acc();
      in_valid = 1'b0;
      wait_hs(n);
      chk("latency", 32'(n), 32'd2);
      chk("table_vec", 32'(last_got), 32'(vecs[i].exp));
      cycle();
      if (i == 1) chk("cnt_corr_first", 32'(cnt_corr), 32'd1);
      if (i == 2) chk("cnt_unc_first", 32'(cnt_unc), 32'd1);
    end

    // Back-to-back stream with the sink stalling every other cycle.
    start = hs_total; tog = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_word = 6'($urandom); in_valid = 1'b1;
      n = 0;
      do begin
        out_ready = tog; tog = ~tog;
        cycle();
        n++;
      end while (!acc_flag && n < 20);
      chk("stream_accept", 32'(acc_flag), 32'd1);
    end
    drain();
    chk("stream_count", 32'(hs_total - start), 32'd8);

    // Counter saturation, then clear colliding with a corrected handoff.
    cnt_clr = 1'b1; cycle(); cnt_clr = 1'b0;
    in_word = 6'b100001; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) wait_acc();
    drain();
    cycle();
    chk("cnt_saturate", 32'(cnt_corr), 32'd3);
    in_word = 6'b100001; in_valid = 1'b1;
    wait_acc();
    in_valid = 1'b0;
    cycle();
    cnt_clr = 1'b1;
    cycle();
    chk("clr_with_handoff", 32'(hs_flag), 32'd1);
    cnt_clr = 1'b0;
    cycle();
    chk("clr_priority", 32'(cnt_corr), 32'd0);

    // Reconfigure to a degenerate matrix with two words in flight.
    out_ready = 1'b0; in_valid = 1'b1;
    in_word = 6'b110001; wait_acc();
    in_word = 6'b100001; wait_acc();
    in_valid = 1'b0;
    h1 = 6'b000011; h2 = 6'b000011; h3 = 6'b100011; cfg_load = 1'b1;
    cycle();
    cfg_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("ack_waits_drain", 32'(s_ack), 32'd0);
      chk("ready_pending", 32'(s_in_ready), 32'd0);
    end
    out_ready = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (!s_ack && n < 12);
    chk("ack_seen", 32'(s_ack), 32'd1);
    chk("ack_after_drain", 32'(sbq.size()), 32'd0);
    cycle();
    chk("ack_pulse", 32'(s_ack), 32'd0);
    in_word = 6'b000001; in_valid = 1'b1;
    wait_acc();
    in_valid = 1'b0;
    wait_hs(n);
    chk("degenerate_unc", 32'(last_got),
        32'({6'b000001, 3'b111, 1'b0, 1'b1, 3'd7, 3'b001}));

    // Random traffic, enables, clears and matrix reloads.
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(9, 0) != 0);
      in_valid = ($urandom_range(3, 0) != 0);
      in_word = 6'($urandom);
      out_ready = ($urandom_range(3, 0) != 0);
      cnt_clr = ($urandom_range(39, 0) == 0);
      cfg_load = ($urandom_range(29, 0) == 0);
      h1 = 6'($urandom); h2 = 6'($urandom); h3 = 6'($urandom);
      cycle();
    end
    drain();

    // Asynchronous reset with words in flight and a configuration pending.
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_word = 6'($urandom);
      cycle();
    end
    cfg_load = 1'b1;
    cycle();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outputs", 32'({obs, cnt_corr, cnt_unc}),
        32'({6'd0, 3'd0, 1'b0, 1'b0, 3'd7, 3'd0, 2'd0, 2'd0}));
    model_reset();
    cfg_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    h1 = D1; h2 = D2; h3 = D3;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst_drops_pending", 32'(in_ready), 32'd1);
    in_word = 6'b100001; in_valid = 1'b1;
    wait_acc();
    in_valid = 1'b0;
    wait_hs(n);
    chk("post_reset_decode", 32'(last_got),
        32'({6'b110001, 3'b010, 1'b1, 1'b0, 3'd4, 3'b001}));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
